// File: rtl/tmds_pkg.sv
// Shared TMDS definitions used by the HDMI transmit encoder and receive decoder.
package tmds_pkg;

  // Running-disparity counter width; |cnt| never exceeds 10.
  localparam int TMDS_CNT_W = 5;

  // Control-period characters, indexed by {C1,C0}.
  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  // Number of set bits in an 8-bit word (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// One-channel TMDS 8b/10b encoder: transition minimisation, then DC balance
// against a running disparity. Four register ranks give inputs-to-output
// latency of 3 cycles after the sampling edge, one character per clock.
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       i_pixclk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic       i_de,
  output logic [9:0] o_tmds,
  output logic       o_de
);

  // Transition-minimised word: bit 8 set means the XOR chain was used.
  function automatic logic [8:0] build_qm(input logic [7:0] d, input logic [3:0] n1);
    logic       use_xnor;
    logic [8:0] qm;
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOK_00;
      2'b01:   tok = CTRL_TOK_01;
      2'b10:   tok = CTRL_TOK_10;
      default: tok = CTRL_TOK_11;
    endcase
    return tok;
  endfunction

  logic [7:0]                   data_p0_d, data_p0_q;
  logic [3:0]                   n1_p0_d, n1_p0_q;
  logic [1:0]                   ctrl_p0_d, ctrl_p0_q;
  logic                         de_p0_d, de_p0_q;
  logic [8:0]                   qm_p1_d, qm_p1_q;
  logic [3:0]                   n1_p1_d, n1_p1_q;
  logic [1:0]                   ctrl_p1_d, ctrl_p1_q;
  logic                         de_p1_d, de_p1_q;
  logic [9:0]                   tmds_p2_d, tmds_p2_q;
  logic                         de_p2_d, de_p2_q;
  logic signed [TMDS_CNT_W-1:0] cnt_d, cnt_q;
  logic [9:0]                   tmds_p3_d, tmds_p3_q;
  logic                         de_p3_d, de_p3_q;

  logic signed [5:0] cnt_ext, disp, two_qm8, two_nqm8, cnt_sum;

  // Stage boundary p0: capture inputs and their popcount.
  always_comb begin
    data_p0_d = i_data;
    n1_p0_d   = popcount8(i_data);
    ctrl_p0_d = i_ctrl;
    de_p0_d   = i_de;
  end

  // Stage boundary p1: transition-minimised word and its popcount.
  always_comb begin
    qm_p1_d   = build_qm(data_p0_q, n1_p0_q);
    n1_p1_d   = popcount8(qm_p1_d[7:0]);
    ctrl_p1_d = ctrl_p0_q;
    de_p1_d   = de_p0_q;
  end

  // Stage boundary p2: DC-balance choice and disparity update, or control token.
  always_comb begin
    cnt_ext   = {cnt_q[TMDS_CNT_W-1], cnt_q};
    disp      = $signed({1'b0, n1_p1_q, 1'b0}) - 6'sd8;
    two_qm8   = $signed({4'b0000, qm_p1_q[8], 1'b0});
    two_nqm8  = $signed({4'b0000, ~qm_p1_q[8], 1'b0});
    tmds_p2_d = ctrl_token(ctrl_p1_q);
    cnt_sum   = '0;
    de_p2_d   = de_p1_q;
    if (de_p1_q) begin
      if ((cnt_ext == 6'sd0) || (disp == 6'sd0)) begin
        tmds_p2_d = {~qm_p1_q[8], qm_p1_q[8], qm_p1_q[8] ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
        cnt_sum   = qm_p1_q[8] ? (cnt_ext + disp) : (cnt_ext - disp);
      end else if (((cnt_ext > 6'sd0) && (disp > 6'sd0)) ||
                   ((cnt_ext < 6'sd0) && (disp < 6'sd0))) begin
        tmds_p2_d = {1'b1, qm_p1_q[8], ~qm_p1_q[7:0]};
        cnt_sum   = cnt_ext + two_qm8 - disp;
      end else begin
        tmds_p2_d = {1'b0, qm_p1_q[8], qm_p1_q[7:0]};
        cnt_sum   = cnt_ext + disp - two_nqm8;
      end
    end
    cnt_d = cnt_sum[TMDS_CNT_W-1:0];
  end

  // Stage boundary p3: output register toward the serializer.
  always_comb begin
    tmds_p3_d = tmds_p2_q;
    de_p3_d   = de_p2_q;
  end

  // Control path and disparity state: reset flushes every in-flight character.
  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      ctrl_p0_q <= 2'b00;
      de_p0_q   <= 1'b0;
      ctrl_p1_q <= 2'b00;
      de_p1_q   <= 1'b0;
      tmds_p2_q <= CTRL_TOK_00;
      de_p2_q   <= 1'b0;
      cnt_q     <= '0;
      tmds_p3_q <= CTRL_TOK_00;
      de_p3_q   <= 1'b0;
    end else begin
      ctrl_p0_q <= ctrl_p0_d;
      de_p0_q   <= de_p0_d;
      ctrl_p1_q <= ctrl_p1_d;
      de_p1_q   <= de_p1_d;
      tmds_p2_q <= tmds_p2_d;
      de_p2_q   <= de_p2_d;
      cnt_q     <= cnt_d;
      tmds_p3_q <= tmds_p3_d;
      de_p3_q   <= de_p3_d;
    end
  end

  // Data path: qualified by the de flags, so no reset needed.
  always_ff @(posedge i_pixclk) begin
    data_p0_q <= data_p0_d;
    n1_p0_q   <= n1_p0_d;
    qm_p1_q   <= qm_p1_d;
    n1_p1_q   <= n1_p1_d;
  end

  assign o_tmds = tmds_p3_q;
  assign o_de   = de_p3_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: directed scenarios plus randomized traffic scored
// against a character-level encoder model, a decoder model and the observed
// running disparity of the output stream.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic [9:0] tmds;
  logic       ode;

  always #5 clk = ~clk;

  tmds_encoder dut (
    .i_pixclk(clk),
    .i_rst   (rst),
    .i_data  (data),
    .i_ctrl  (ctrl),
    .i_de    (de),
    .o_tmds  (tmds),
    .o_de    (ode)
  );

  typedef struct {
    logic [9:0] chr;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t       pipe [4];
  int         mcnt;
  int         rd;
  int         n_vec;
  int         n_err;
  logic [9:0] out_hist [$];
  int         rd_hist  [$];
  logic [9:0] tok      [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // Character-level encoder with its own running disparity (mcnt).
  function automatic logic [9:0] model_enc(input logic d_e, input logic [7:0] d,
                                           input logic [1:0] c);
    int         n1;
    int         ones;
    int         diff;
    int         q8;
    bit         use_xnor;
    logic [8:0] qm;
    logic [9:0] chr;
    if (!d_e) begin
      mcnt = 0;
      return tok[c];
    end
    n1       = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = !use_xnor;
    q8    = use_xnor ? 0 : 1;
    ones  = $countones(qm[7:0]);
    diff  = ones - (8 - ones);
    if (mcnt == 0 || diff == 0) begin
      chr  = {~qm[8], qm[8], (q8 == 1) ? qm[7:0] : ~qm[7:0]};
      mcnt = mcnt + ((q8 == 1) ? diff : -diff);
    end else if ((mcnt > 0 && diff > 0) || (mcnt < 0 && diff < 0)) begin
      chr  = {1'b1, qm[8], ~qm[7:0]};
      mcnt = mcnt + 2 * q8 - diff;
    end else begin
      chr  = {1'b0, qm[8], qm[7:0]};
      mcnt = mcnt + diff - 2 * (1 - q8);
    end
    return chr;
  endfunction

  // Receiver-side decoder: returns {de, payload}.
  function automatic logic [8:0] decode(input logic [9:0] c);
    logic [7:0] x;
    logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      if (c == tok[k]) return {1'b0, 6'd0, k[1:0]};
    end
    x    = c[9] ? ~c[7:0] : c[7:0];
    d    = '0;
    d[0] = x[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = c[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    end
    return {1'b1, d};
  endfunction

  task automatic tick();
    exp_t       e;
    logic [8:0] dec;
    if (rst) begin
      mcnt = 0;
      for (int i = 0; i < 4; i++) pipe[i] = '{10'h354, 1'b0, 8'h00, 2'b00};
    end else begin
      e.chr   = model_enc(de, data, ctrl);
      e.de    = de;
      e.data  = data;
      e.ctrl  = ctrl;
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
    end
    @(posedge clk);
    #1;
    out_hist.push_back(tmds);
    check_eq("tmds", tmds, pipe[3].chr);
    check_eq("de", ode, pipe[3].de);
    dec = decode(tmds);
    check_eq("dec_de", dec[8], pipe[3].de);
    if (pipe[3].de) check_eq("dec_data", dec[7:0], pipe[3].data);
    else            check_eq("dec_ctrl", dec[1:0], pipe[3].ctrl);
    if (ode === 1'b1) rd = rd + 2 * $countones(tmds) - 10;
    else              rd = 0;
    rd_hist.push_back(rd);
    check_eq("rd_bound", (rd <= 10 && rd >= -10), 1);
  endtask

  task automatic drive(input logic d_e, input logic [7:0] d, input logic [1:0] c);
    de   = d_e;
    data = d;
    ctrl = c;
    tick();
  endtask

  task automatic flush();
    repeat (3) drive(1'b0, 8'h00, 2'b00);
  endtask

  initial begin
    int base;
    n_vec = 0;
    n_err = 0;
    rd    = 0;
    mcnt  = 0;
    for (int i = 0; i < 4; i++) pipe[i] = '{10'h354, 1'b0, 8'h00, 2'b00};

    // Reset with live data on the inputs.
    rst  = 1'b1;
    de   = 1'b1;
    data = 8'hA5;
    ctrl = 2'b11;
    repeat (2) begin
      tick();
      check_eq("rst_tmds", tmds, 10'h354);
      check_eq("rst_de", ode, 1'b0);
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_eq("post_rst_tmds", tmds, 10'h354);
      check_eq("post_rst_de", ode, 1'b0);
    end
    tick();
    check_eq("first_data", tmds, 10'h163);
    check_eq("first_de", ode, 1'b1);
    repeat (4) drive(1'b0, 8'h00, 2'b00);

    // Control tokens.
    base = out_hist.size();
    for (int c = 0; c < 4; c++) drive(1'b0, 8'hFF, c[1:0]);
    flush();
    for (int i = 0; i < 4; i++) begin
      check_eq("ctrl_tok", out_hist[base+3+i], tok[i]);
    end

    // Disparity toggling on all-zero data.
    base = out_hist.size();
    repeat (4) drive(1'b1, 8'h00, 2'b00);
    flush();
    check_eq("zero0", out_hist[base+3], 10'h100);
    check_eq("zero1", out_hist[base+4], 10'h3FF);
    check_eq("zero2", out_hist[base+5], 10'h100);
    check_eq("zero3", out_hist[base+6], 10'h3FF);
    check_eq("zero_rd0", rd_hist[base+3], -8);
    check_eq("zero_rd1", rd_hist[base+4], 2);
    check_eq("zero_rd2", rd_hist[base+5], -6);
    check_eq("zero_rd3", rd_hist[base+6], 4);

    // XNOR path on all-ones data.
    base = out_hist.size();
    repeat (2) drive(1'b1, 8'hFF, 2'b00);
    flush();
    check_eq("ones0", out_hist[base+3], 10'h200);
    check_eq("ones1", out_hist[base+4], 10'h0FF);
    check_eq("ones_rd0", rd_hist[base+3], -8);
    check_eq("ones_rd1", rd_hist[base+4], -2);

    // One control clock clears the disparity.
    base = out_hist.size();
    drive(1'b1, 8'h00, 2'b00);
    drive(1'b0, 8'h00, 2'b00);
    drive(1'b1, 8'h00, 2'b00);
    flush();
    check_eq("clr0", out_hist[base+3], 10'h100);
    check_eq("clr1", out_hist[base+4], 10'h354);
    check_eq("clr2", out_hist[base+5], 10'h100);

    // de alternating every clock.
    for (int i = 0; i < 24; i++) begin
      drive(i[0], 8'($urandom), 2'($urandom));
    end

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (i % 2000 < 1000) drive(($urandom_range(0, 7) != 0), 8'($urandom), 2'($urandom));
      else                 drive($urandom_range(0, 1) == 1, 8'($urandom), 2'($urandom));
    end
    rst = 1'b0;
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
